seg7_capture_decoder: RTL and testbench

Receive-side counterpart of the seven-segment digit/animation driver. It samples a 7-bit segment bus, waits until the pattern has been stable for a set time, and decodes it back to a BCD digit. It then checks that successive digits follow the driver's count-and-wrap sequence. It sits on the input side of a loop-back or tester tile and reports digits, invalid patterns and sequence errors.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_pattern_lut.sv | 42 ++++
 rtl/seg7_capture_decoder.sv | 150 +++++++++++++++
 tb/tb_seg7_capture_decoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Segment encodings, FSM states and helpers for the 7-seg capture decoder
// Revision : 1.0
// ============================================================================
package seg7_pkg;

    localparam int DIGIT_W = 4;

    // Active-high segment bus, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_6_ALT = 7'h7C;
    localparam logic [6:0] SEG_9_ALT = 7'h67;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [DIGIT_W-1:0] clamp_wrap(input logic [DIGIT_W-1:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_lut.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pattern_lut
// Purpose  : Combinational segment-pattern to BCD digit decode
// Revision : 1.0
// ============================================================================
module seg7_pattern_lut
    import seg7_pkg::*;
(
    input  logic [6:0]         pattern,
    output logic [DIGIT_W-1:0] digit,
    output logic               is_digit,
    output logic               is_blank
);

    always_comb begin
        digit    = '0;
        is_digit = 1'b1;
        is_blank = 1'b0;
        case (pattern)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_6_ALT: digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_9_ALT: digit = 4'd9;
            SEG_BLANK: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_digit = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_capture_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_capture_decoder
// Purpose  : Synchronise, debounce and decode a 7-seg bus; check count-and-wrap
// Revision : 1.0
// ============================================================================
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         segments_in,
    input  logic               sample_en,
    input  logic [3:0]         seq_max,
    output logic [DIGIT_W-1:0] digit_out,
    output logic               digit_valid,
    output logic               pattern_err,
    output logic               seq_err,
    output logic [ERR_W-1:0]   err_count,
    output logic [1:0]         state_out
);

    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

    logic [6:0]         r_sync1;
    logic [6:0]         r_seg_s;
    logic [6:0]         r_candidate;
    logic [7:0]         r_stab_cnt;
    state_t             r_state;
    logic [DIGIT_W-1:0] r_digit;
    logic               r_digit_valid;
    logic               r_pattern_err;
    logic               r_seq_err;
    logic [ERR_W-1:0]   r_err_count;
    logic               r_hist_valid;

    logic [6:0]         w_candidate_nxt;
    logic [7:0]         w_stab_cnt_nxt;
    state_t             w_state_nxt;
    logic [DIGIT_W-1:0] w_digit_nxt;
    logic               w_digit_valid_nxt;
    logic               w_pattern_err_nxt;
    logic               w_seq_err_nxt;
    logic [ERR_W-1:0]   w_err_count_nxt;
    logic               w_hist_valid_nxt;
    logic [DIGIT_W-1:0] w_expected;
    logic [DIGIT_W-1:0] w_lut_digit;
    logic               w_lut_is_digit;
    logic               w_lut_is_blank;

    seg7_pattern_lut u_lut (
        .pattern  (r_seg_s),
        .digit    (w_lut_digit),
        .is_digit (w_lut_is_digit),
        .is_blank (w_lut_is_blank)
    );

    assign w_expected = (r_digit == clamp_wrap(seq_max)) ? 4'd0 : r_digit + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_seg_s <= '0;
        end else begin
            r_sync1 <= segments_in;
            r_seg_s <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_candidate   <= '0;
            r_stab_cnt    <= '0;
            r_digit       <= '0;
            r_digit_valid <= 1'b0;
            r_pattern_err <= 1'b0;
            r_seq_err     <= 1'b0;
            r_err_count   <= '0;
            r_hist_valid  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_candidate   <= w_candidate_nxt;
            r_stab_cnt    <= w_stab_cnt_nxt;
            r_digit       <= w_digit_nxt;
            r_digit_valid <= w_digit_valid_nxt;
            r_pattern_err <= w_pattern_err_nxt;
            r_seq_err     <= w_seq_err_nxt;
            r_err_count   <= w_err_count_nxt;
            r_hist_valid  <= w_hist_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_candidate_nxt   = r_candidate;
        w_stab_cnt_nxt    = r_stab_cnt;
        w_digit_nxt       = r_digit;
        w_digit_valid_nxt = 1'b0;
        w_pattern_err_nxt = 1'b0;
        w_seq_err_nxt     = 1'b0;
        w_hist_valid_nxt  = r_hist_valid;

        if (!sample_en) begin
            w_state_nxt      = IDLE;
            w_candidate_nxt  = '0;
            w_stab_cnt_nxt   = '0;
            w_hist_valid_nxt = 1'b0;
        end else if (r_seg_s != r_candidate) begin
            // A change always restarts the settle, even on the accept cycle
            w_candidate_nxt = r_seg_s;
            w_stab_cnt_nxt  = '0;
            w_state_nxt     = SETTLE;
        end else if (r_state == SETTLE) begin
            if (r_stab_cnt < STAB_LAST) begin
                w_stab_cnt_nxt = r_stab_cnt + 8'd1;
            end else if (w_lut_is_blank) begin
                w_state_nxt      = IDLE;
                w_hist_valid_nxt = 1'b0;
            end else if (w_lut_is_digit) begin
                w_digit_nxt       = w_lut_digit;
                w_digit_valid_nxt = 1'b1;
                w_seq_err_nxt     = r_hist_valid && (w_lut_digit != w_expected);
                w_hist_valid_nxt  = 1'b1;
                w_state_nxt       = LOCKED;
            end else begin
                w_pattern_err_nxt = 1'b1;
                w_state_nxt       = LOCKED;
            end
        end
    end

    always_comb begin
        w_err_count_nxt = r_err_count;
        if ((w_pattern_err_nxt || w_seq_err_nxt) && (r_err_count != {ERR_W{1'b1}}))
            w_err_count_nxt = r_err_count + ERR_W'(1);
    end

    assign digit_out   = r_digit;
    assign digit_valid = r_digit_valid;
    assign pattern_err = r_pattern_err;
    assign seq_err     = r_seq_err;
    assign err_count   = r_err_count;
    assign state_out   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_capture_decoder
// Purpose  : Directed scoreboard bench for seg7_capture_decoder
// Revision : 1.0
// ============================================================================
module tb_seg7_capture_decoder;

    logic       clk;
    logic       reset;
    logic [6:0] segments_in;
    logic       sample_en;
    logic [3:0] seq_max;
    logic [3:0] digit_out;
    logic       digit_valid;
    logic       pattern_err;
    logic       seq_err;
    logic [7:0] err_count;
    logic [1:0] state_out;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected event: {digit_valid, pattern_err, seq_err, digit_out[3:0], err_count[7:0]}
    logic [31:0] sb[$];

    int       m_prev;
    bit       m_hist;
    int       m_errc;
    logic [7:0] last_pat;

    seg7_capture_decoder #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .segments_in (segments_in),
        .sample_en   (sample_en),
        .seq_max     (seq_max),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .pattern_err (pattern_err),
        .seq_err     (seq_err),
        .err_count   (err_count),
        .state_out   (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [6:0] p);
        case (p)
            7'h3F: return 0;
            7'h06: return 1;
            7'h5B: return 2;
            7'h4F: return 3;
            7'h66: return 4;
            7'h6D: return 5;
            7'h7D, 7'h7C: return 6;
            7'h07: return 7;
            7'h7F: return 8;
            7'h6F, 7'h67: return 9;
            7'h00: return -1;
            default: return -2;
        endcase
    endfunction

    task automatic model_accept(input logic [6:0] pat);
        int d;
        int wrap;
        int exp_d;
        bit se;
        d = decode(pat);
        if (d == -1) begin
            m_hist = 1'b0;
        end else if (d >= 0) begin
            wrap  = (seq_max > 9) ? 9 : int'(seq_max);
            exp_d = (m_prev == wrap) ? 0 : m_prev + 1;
            se    = m_hist && (d != exp_d);
            m_prev = d;
            m_hist = 1'b1;
            if (se && m_errc < 255) m_errc++;
            sb.push_back({17'd0, 1'b1, 1'b0, se, 4'(d), 8'(m_errc)});
        end else begin
            if (m_errc < 255) m_errc++;
            sb.push_back({17'd0, 1'b0, 1'b1, 1'b0, 4'(m_prev), 8'(m_errc)});
        end
    endtask

    task automatic model_reset();
        m_prev   = 0;
        m_hist   = 1'b0;
        m_errc   = 0;
        last_pat = 8'h00;
        sb.delete();
    endtask

    task automatic apply(input logic [6:0] pat, input int n);
        @(negedge clk);
        segments_in = pat;
        if ({1'b0, pat} != last_pat) model_accept(pat);
        last_pat = {1'b0, pat};
        repeat (n) @(negedge clk);
        check("sb_drain", sb.size(), 0);
    endtask

    task automatic wait_latency(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!digit_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check(tag, lat, exp_lat);
    endtask

    always @(negedge clk) begin
        if (!reset && (digit_valid || pattern_err || seq_err)) begin
            if (sb.size() == 0)
                check("unexpected_pulse", {29'd0, digit_valid, pattern_err, seq_err}, 32'd0);
            else
                check("event", {17'd0, digit_valid, pattern_err, seq_err, digit_out, err_count},
                      sb.pop_front());
        end
    end

    initial begin
        reset       = 1'b1;
        sample_en   = 1'b1;
        seq_max     = 4'd9;
        segments_in = 7'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_digit", digit_out, 0);
        check("rst_pulses", {digit_valid, pattern_err, seq_err}, 0);
        check("rst_errc", err_count, 0);
        check("rst_state", state_out, 0);
        reset = 1'b0;

        // Single held digit: accept 6 edges after first sample
        @(negedge clk);
        segments_in = 7'h5B;
        model_accept(7'h5B);
        last_pat = 8'h5B;
        wait_latency("latency_first", 7);
        repeat (4) @(negedge clk);
        check("digit_first", digit_out, 2);
        check("state_locked", state_out, 2);
        check("sb_first", sb.size(), 0);

        // Full count 0..9 then wrap to 0
        apply(7'h00, 8);
        check("state_idle_blank", state_out, 0);
        begin
            logic [6:0] tbl [10];
            tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
            for (int i = 0; i < 10; i++) apply(tbl[i], 8);
            apply(7'h3F, 8);
        end
        check("errc_count", err_count, 0);

        // Wrap at 5: digit 6 breaks the sequence; blank clears history
        seq_max = 4'd5;
        apply(7'h00, 8);
        apply(7'h66, 8);
        apply(7'h6D, 8);
        apply(7'h7C, 8);
        check("errc_seq", err_count, 1);
        apply(7'h00, 8);
        apply(7'h3F, 8);
        apply(7'h06, 8);

        // Invalid pattern
        apply(7'h49, 8);
        check("digit_after_inv", digit_out, 1);
        check("errc_inv", err_count, 2);

        // Chatter shorter than the settle window never accepts
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            segments_in = (i % 2 == 0) ? 7'h06 : 7'h5B;
            repeat (2) @(negedge clk);
        end
        last_pat = 8'hFF;
        apply(7'h5B, 10);
        check("digit_after_toggle", digit_out, 2);

        // Capture disabled: idle, outputs held, history dropped
        @(negedge clk);
        sample_en   = 1'b0;
        segments_in = 7'h4F;
        repeat (10) @(negedge clk);
        check("dis_state", state_out, 0);
        check("dis_digit", digit_out, 2);
        m_hist   = 1'b0;
        last_pat = 8'h00;
        sample_en = 1'b1;
        apply(7'h4F, 8);

        // Reset in the middle of a settle
        @(negedge clk);
        segments_in = 7'h7D;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_digit", digit_out, 0);
        check("midrst_errc", err_count, 0);
        check("midrst_state", state_out, 0);
        check("midrst_pulses", {digit_valid, pattern_err, seq_err}, 0);
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b0;
        model_accept(7'h7D);
        last_pat = 8'h7D;
        wait_latency("latency_after_rst", 7);
        repeat (3) @(negedge clk);
        check("digit_after_rst", digit_out, 6);

        // Saturation of the error counter
        for (int i = 0; i < 300; i++) apply((i % 2 == 0) ? 7'h49 : 7'h76, 8);
        check("errc_sat", err_count, 255);
        check("digit_sat", digit_out, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
